bus_arbiter: RTL and testbench

// Round-robin arbiter sharing the single slave port of the address-decoding interconnect between
// NUM_REQ bus requesters (CPU, DMA, debug). One transfer is granted at a time and held until

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the requester-to-interconnect bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request strictly after last_grant,
// wrapping around, so the previous winner has lowest priority.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   always_comb begin
      int unsigned cand;
      cand      = 0;
      grant_idx = '0;
      any_req   = 1'b0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = 32'(last_grant) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!any_req && req[cand[IDX_W-1:0]]) begin
            any_req   = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between NUM_REQ requesters,
// with a watchdog that aborts transfers stalled by waitrequest.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ*ADDR_W-1:0]  s_bus_addr,
   input  logic [NUM_REQ-1:0]         s_bus_read,
   input  logic [NUM_REQ-1:0]         s_bus_write,
   input  logic [NUM_REQ*DATA_W-1:0]  s_bus_writedata,
   input  logic [NUM_REQ*BE_W-1:0]    s_bus_byteenable,
   output logic [NUM_REQ*DATA_W-1:0]  s_bus_readdata,
   output logic [NUM_REQ*2-1:0]       s_bus_response,
   output logic [NUM_REQ-1:0]         s_bus_waitrequest,
   output logic [ADDR_W-1:0]          m_bus_addr,
   output logic                       m_bus_read,
   output logic                       m_bus_write,
   output logic [DATA_W-1:0]          m_bus_writedata,
   output logic [BE_W-1:0]            m_bus_byteenable,
   input  logic [DATA_W-1:0]          m_bus_readdata,
   input  logic [1:0]                 m_bus_response,
   input  logic                       m_bus_waitrequest,
   output logic                       stat_busy,
   output logic                       stat_timeout
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

   arb_state_e state, state_next;

   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               any_req;
   logic [CNT_W-1:0]   wd_count;
   logic               wd_expire;
   logic [NUM_REQ-1:0] req;
   logic               granted_req;
   logic [DATA_W-1:0]  rdata_mux;
   logic [1:0]         resp_mux;

   logic [ADDR_W-1:0]  addr_slv  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_slv [NUM_REQ];
   logic [BE_W-1:0]    be_slv    [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_slv[g]  = s_bus_addr[g*ADDR_W +: ADDR_W];
      assign wdata_slv[g] = s_bus_writedata[g*DATA_W +: DATA_W];
      assign be_slv[g]    = s_bus_byteenable[g*BE_W +: BE_W];
   end

   assign req         = s_bus_read | s_bus_write;
   assign granted_req = req[grant_idx];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant_idx  (pick_idx),
      .any_req    (any_req)
   );

   // Counter has counted TIMEOUT_CYCLES stalled cycles once this cycle's stall is added.
   assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_count == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= LAST_INIT;
         wd_count   <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && any_req) begin
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            wd_count   <= '0;
         end else if (state == BUSY && m_bus_waitrequest) begin
            wd_count <= wd_count + CNT_W'(1);
         end
      end
   end

   // Strobes and the granted waitrequest are gated by rst so an abandoned
   // transfer disappears from both sides in the reset cycle itself.
   always_comb begin
      state_next        = state;
      m_bus_read        = 1'b0;
      m_bus_write       = 1'b0;
      s_bus_waitrequest = '1;
      rdata_mux         = m_bus_readdata;
      resp_mux          = m_bus_response;
      stat_timeout      = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            m_bus_read  = s_bus_read[grant_idx] & ~rst;
            m_bus_write = s_bus_write[grant_idx] & ~rst;
            if (granted_req && !rst) begin
               s_bus_waitrequest[grant_idx] = m_bus_waitrequest;
            end
            if (!granted_req || !m_bus_waitrequest) begin
               state_next = IDLE;
            end else if (wd_expire) begin
               state_next = ABORT;
            end
         end
         ABORT: begin
            rdata_mux  = '0;
            resp_mux   = RESP_SLVERR;
            state_next = IDLE;
            if (!rst) begin
               s_bus_waitrequest[grant_idx] = 1'b0;
               stat_timeout                 = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign m_bus_addr       = addr_slv[grant_idx];
   assign m_bus_writedata  = wdata_slv[grant_idx];
   assign m_bus_byteenable = be_slv[grant_idx];

   assign s_bus_readdata = {NUM_REQ{rdata_mux}};
   assign s_bus_response = {NUM_REQ{resp_mux}};
   assign stat_busy      = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter: a transfer-level model predicts
// each completion (who, data, response, abort) and a monitor checks it.
module tb_bus_arbiter;
   import bus_arb_pkg::*;

   localparam int unsigned N   = 3;
   localparam int unsigned TMO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*32-1:0] s_bus_addr;
   logic [N-1:0]    s_bus_read;
   logic [N-1:0]    s_bus_write;
   logic [N*32-1:0] s_bus_writedata;
   logic [N*4-1:0]  s_bus_byteenable;
   logic [N*32-1:0] s_bus_readdata;
   logic [N*2-1:0]  s_bus_response;
   logic [N-1:0]    s_bus_waitrequest;
   logic [31:0]     m_bus_addr;
   logic            m_bus_read;
   logic            m_bus_write;
   logic [31:0]     m_bus_writedata;
   logic [3:0]      m_bus_byteenable;
   logic [31:0]     m_bus_readdata;
   logic [1:0]      m_bus_response;
   logic            m_bus_waitrequest;
   logic            stat_busy;
   logic            stat_timeout;

   always #5 clk = ~clk;

   bus_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .s_bus_addr        (s_bus_addr),
      .s_bus_read        (s_bus_read),
      .s_bus_write       (s_bus_write),
      .s_bus_writedata   (s_bus_writedata),
      .s_bus_byteenable  (s_bus_byteenable),
      .s_bus_readdata    (s_bus_readdata),
      .s_bus_response    (s_bus_response),
      .s_bus_waitrequest (s_bus_waitrequest),
      .m_bus_addr        (m_bus_addr),
      .m_bus_read        (m_bus_read),
      .m_bus_write       (m_bus_write),
      .m_bus_writedata   (m_bus_writedata),
      .m_bus_byteenable  (m_bus_byteenable),
      .m_bus_readdata    (m_bus_readdata),
      .m_bus_response    (m_bus_response),
      .m_bus_waitrequest (m_bus_waitrequest),
      .stat_busy         (stat_busy),
      .stat_timeout      (stat_timeout)
   );

   typedef struct {
      int unsigned who;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;

   typedef enum {M_FREE, M_BUSY, M_ABORT} model_phase_e;

   exp_t        exp_q[$];
   exp_t        m_e;
   logic [N-1:0] m_lo;
   int unsigned errors = 0;
   int unsigned checks = 0;
   logic        mon_en = 1'b0;

   // Requester transaction table: a pending entry is held until it completes.
   logic        pend    [N];
   logic [31:0] t_addr  [N];
   logic        t_rd    [N];
   logic        t_wr    [N];
   logic [31:0] t_wdata [N];
   logic [3:0]  t_be    [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < int'(N); i++) begin
         s_bus_read[i]             = pend[i] & t_rd[i];
         s_bus_write[i]            = pend[i] & t_wr[i];
         s_bus_addr[i*32 +: 32]    = t_addr[i];
         s_bus_writedata[i*32 +: 32] = t_wdata[i];
         s_bus_byteenable[i*4 +: 4]  = t_be[i];
      end
   endtask

   task automatic push_exp(input int unsigned who, input logic tmo);
      exp_t e;
      e.who   = who;
      e.addr  = t_addr[who];
      e.rd    = t_rd[who];
      e.wr    = t_wr[who];
      e.wdata = t_wdata[who];
      e.be    = t_be[who];
      e.rdata = tmo ? 32'h0 : m_bus_readdata;
      e.resp  = tmo ? RESP_SLVERR : m_bus_response;
      e.tmo   = tmo;
      exp_q.push_back(e);
   endtask

   // Monitor: any requester seeing waitrequest low is a completion to be matched.
   always @(negedge clk) begin
      if (mon_en) begin
         m_lo = ~s_bus_waitrequest;
         if (m_lo != '0 || exp_q.size() != 0) begin
            if (exp_q.size() == 0) begin
               check("spurious_completion", 32'(m_lo), 32'h0);
            end else begin
               m_e = exp_q.pop_front();
               check("grant_who", 32'(m_lo), 32'(1) << m_e.who);
               check("readdata", s_bus_readdata[m_e.who*32 +: 32], m_e.rdata);
               check("response", 32'(s_bus_response[m_e.who*2 +: 2]), 32'(m_e.resp));
               check("stat_timeout", 32'(stat_timeout), 32'(m_e.tmo));
               if (m_e.tmo) begin
                  check("abort_strobes", 32'({m_bus_read, m_bus_write}), 32'h0);
               end else begin
                  check("m_addr", m_bus_addr, m_e.addr);
                  check("m_strobes", 32'({m_bus_read, m_bus_write}), 32'({m_e.rd, m_e.wr}));
                  check("m_wdata", m_bus_writedata, m_e.wdata);
                  check("m_be", 32'(m_bus_byteenable), 32'(m_e.be));
               end
            end
         end
      end
   end

   initial begin
      model_phase_e phase;
      int unsigned  last, owner, waited, wait_target, kind;
      int           retire_who;
      logic         first_grant;
      logic         found;

      rst = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         pend[i] = 1'b0; t_addr[i] = '0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
         t_wdata[i] = '0; t_be[i] = '0;
      end
      drive_req();
      m_bus_readdata    = '0;
      m_bus_response    = RESP_OKAY;
      m_bus_waitrequest = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stat_busy", 32'(stat_busy), 32'h0);
      check("rst_stat_timeout", 32'(stat_timeout), 32'h0);
      check("rst_waitreq", 32'(s_bus_waitrequest), 32'h7);
      check("rst_m_read", 32'(m_bus_read), 32'h0);
      check("rst_m_write", 32'(m_bus_write), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      phase       = M_FREE;
      last        = N - 1;
      owner       = 0;
      waited      = 0;
      wait_target = 0;
      retire_who  = -1;
      first_grant = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (retire_who >= 0) begin
            pend[retire_who] = 1'b0;
            retire_who = -1;
         end
         if (cyc == 0) begin
            pend[0] = 1'b1; t_addr[0] = 32'h104; t_rd[0] = 1'b1; t_wr[0] = 1'b0;
            t_wdata[0] = '0; t_be[0] = 4'hF;
         end else if (cyc < 2500) begin
            for (int i = 0; i < int'(N); i++) begin
               if (!pend[i] && $urandom_range(0, 3) == 0) begin
                  kind       = $urandom_range(0, 4);
                  pend[i]    = 1'b1;
                  t_addr[i]  = $urandom;
                  t_wdata[i] = $urandom;
                  t_be[i]    = 4'($urandom);
                  t_rd[i]    = (kind != 1 && kind != 2);
                  t_wr[i]    = (kind != 0 && kind != 3);
               end
            end
         end
         m_bus_readdata = (cyc == 1) ? 32'hCAFE_0001 : 32'($urandom);
         case ($urandom_range(0, 2))
            0:       m_bus_response = RESP_OKAY;
            1:       m_bus_response = RESP_SLVERR;
            default: m_bus_response = RESP_DECERR;
         endcase
         if (cyc == 1) m_bus_response = RESP_OKAY;

         case (phase)
            M_FREE: begin
               m_bus_waitrequest = 1'($urandom_range(0, 1));
               found = 1'b0;
               for (int unsigned k = 1; k <= N; k++) begin
                  if (!found && pend[(last + k) % N]) begin
                     found = 1'b1;
                     owner = (last + k) % N;
                  end
               end
               if (found) begin
                  last   = owner;
                  waited = 0;
                  phase  = M_BUSY;
                  if (first_grant) begin
                     wait_target = 0;
                     first_grant = 1'b0;
                  end else if ($urandom_range(0, 9) < 6) begin
                     wait_target = $urandom_range(0, 3);
                  end else begin
                     wait_target = $urandom_range(TMO - 2, TMO + 3);
                  end
               end
            end
            M_BUSY: begin
               m_bus_waitrequest = (waited < wait_target);
               if (!m_bus_waitrequest) begin
                  push_exp(owner, 1'b0);
                  retire_who = int'(owner);
                  phase = M_FREE;
               end else begin
                  waited++;
                  if (waited == TMO) phase = M_ABORT;
               end
            end
            default: begin
               m_bus_waitrequest = 1'($urandom_range(0, 1));
               push_exp(owner, 1'b1);
               retire_who = int'(owner);
               phase = M_FREE;
            end
         endcase
         drive_req();
         mon_en = 1'b1;
      end

      @(negedge clk);
      mon_en = 1'b0;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      // Reset in the second BUSY cycle of a requester-2 transfer.
      @(posedge clk); #1;
      for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
      pend[2] = 1'b1; t_rd[2] = 1'b1; t_wr[2] = 1'b0; t_addr[2] = 32'h0000_2000;
      m_bus_waitrequest = 1'b1;
      drive_req();
      @(posedge clk); #1;
      @(negedge clk);
      check("r2_stat_busy", 32'(stat_busy), 32'h1);
      check("r2_stalled_waitreq", 32'(s_bus_waitrequest), 32'h7);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_strobe_drop", 32'({m_bus_read, m_bus_write}), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         pend[i] = 1'b1; t_rd[i] = 1'b1; t_wr[i] = 1'b0; t_addr[i] = 32'h100 * (i + 1);
      end
      m_bus_waitrequest = 1'b0;
      drive_req();
      @(negedge clk);
      check("post_rst_busy", 32'(stat_busy), 32'h0);
      check("post_rst_waitreq", 32'(s_bus_waitrequest), 32'h7);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_grant0", 32'(s_bus_waitrequest), 32'h6);
      check("post_rst_addr", m_bus_addr, 32'h100);
      check("post_rst_read", 32'(m_bus_read), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
